i2s_tx: RTL and testbench

I2S master transmitter, the transmit-side counterpart of our I2S receiver. It takes stereo samples from the DSP fabric through a valid/ready handshake. It generates sclk and lrclk from the system clock and serialises left and right words MSB-first on sdo in standard I2S framing: one-bit delay after each lrclk edge, lrclk low means left. Output drives the DAC/codec pins or loops back into the receiver.

---
 rtl/i2s_tx_if.sv | 12 +
 rtl/i2s_tx.sv | 94 +++++++++
 tb/tb_i2s_tx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample handshake between the DSP fabric (master) and the I2S transmitter (slave).
interface i2s_tx_if #(
    parameter int DW = 24
);
    logic [DW-1:0] ldata;
    logic [DW-1:0] rdata;
    logic          valid;
    logic          ready;

    modport master (output ldata, output rdata, output valid, input ready);
    modport slave  (input ldata, input rdata, input valid, output ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: one buffered stereo sample, divided sclk/lrclk,
// MSB-first serialisation with the standard one-bit delay after each lrclk edge.
module i2s_tx #(
    parameter int DW       = 24,
    parameter int FW       = 32,
    parameter int SCLK_DIV = 4
) (
    input  logic    clk,
    input  logic    rst,
    i2s_tx_if.slave bus,
    output logic    sclk,
    output logic    lrclk,
    output logic    sdo,
    output logic    underrun
);
    localparam int CW   = $clog2(2 * FW);
    localparam int DIVW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0]   LAST     = CW'(2 * FW - 1);
    localparam logic [CW-1:0]   FW_C     = CW'(FW);
    localparam logic [CW-1:0]   DW_C     = CW'(DW);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCLK_DIV - 1);

    logic [DIVW-1:0] div_ctr;
    logic [CW-1:0]   bit_ctr;
    logic [DW-1:0]   buf_l, buf_r;
    logic [DW-1:0]   word_l, word_r;

    logic            tick, fall;
    logic [CW-1:0]   nxt_ctr, slot;
    logic [DW-1:0]   word, shifted;
    logic            nxt_sdo;

    // Everything below looks at the bit position the coming falling edge moves to.
    always_comb begin
        tick    = (div_ctr == DIV_LAST);
        fall    = tick && sclk;
        nxt_ctr = (bit_ctr == LAST) ? '0 : bit_ctr + 1'b1;
        slot    = (nxt_ctr >= FW_C) ? nxt_ctr - FW_C : nxt_ctr;
        word    = (nxt_ctr >= FW_C) ? word_r : word_l;
        shifted = word >> (DW_C - slot);
        nxt_sdo = 1'b0;
        if (slot != '0 && slot <= DW_C)
            nxt_sdo = shifted[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_ctr   <= '0;
            sclk      <= 1'b0;
            bit_ctr   <= LAST;
            lrclk     <= 1'b1;
            sdo       <= 1'b0;
            bus.ready <= 1'b1;
            underrun  <= 1'b0;
            buf_l     <= '0;
            buf_r     <= '0;
            word_l    <= '0;
            word_r    <= '0;
        end else begin
            underrun <= 1'b0;
            if (tick) begin
                div_ctr <= '0;
                sclk    <= ~sclk;
            end else begin
                div_ctr <= div_ctr + 1'b1;
            end

            if (fall) begin
                bit_ctr <= nxt_ctr;
                lrclk   <= (nxt_ctr >= FW_C);
                sdo     <= nxt_sdo;
                // Frame load; ready low means the holding buffer is full.
                if (nxt_ctr == '0) begin
                    if (!bus.ready) begin
                        word_l    <= buf_l;
                        word_r    <= buf_r;
                        bus.ready <= 1'b1;
                    end else begin
                        word_l   <= '0;
                        word_r   <= '0;
                        underrun <= 1'b1;
                    end
                end
            end

            // Only possible while empty, so never collides with the load above.
            if (bus.valid && bus.ready) begin
                buf_l     <= bus.ldata;
                buf_r     <= bus.rdata;
                bus.ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx: per-clk reference model of the framing plus a
// loopback I2S receiver that decodes the transmitted words.
module tb_i2s_tx;
    localparam int DW    = 24;
    localparam int FW    = 32;
    localparam int SD    = 4;
    localparam int FRAME = 2 * FW * 2 * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk, lrclk, sdo, underrun;

    always #5 clk = ~clk;

    i2s_tx_if #(.DW(DW)) bus ();

    i2s_tx #(.DW(DW), .FW(FW), .SCLK_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .sdo      (sdo),
        .underrun (underrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model: n = clk edges since reset release
    int            n = 0;
    bit            m_full = 0, m_und = 0, m_acc = 0;
    logic [DW-1:0] m_bl = '0, m_br = '0, m_cl = '0, m_cr = '0;

    function automatic bit is_load(input int e);
        return (e > 0) && (e % (2 * SD) == 0) && (((e / (2 * SD)) - 1) % (2 * FW) == 0);
    endfunction

    task automatic model_edge();
        bit full_prev;
        m_und = 0;
        m_acc = 0;
        if (!rst) begin
            n = 0; m_full = 0; m_cl = '0; m_cr = '0;
        end else begin
            n++;
            full_prev = m_full;
            if (is_load(n)) begin
                if (full_prev) begin
                    m_cl = m_bl; m_cr = m_br; m_full = 0;
                end else begin
                    m_cl = '0; m_cr = '0; m_und = 1;
                end
            end
            if (bus.valid && !full_prev) begin
                m_bl = bus.ldata; m_br = bus.rdata; m_full = 1; m_acc = 1;
            end
        end
    endtask

    // loopback receiver
    logic [DW-1:0] rx_word = '0, rx_left = '0;
    logic [DW-1:0] rx_lq[$], rx_rq[$];
    logic [DW-1:0] push_lq[$], push_rq[$];
    int  rx_pos = 0, cyc = 0, last_rise = -1;
    bit  prev_sclk = 0, prev_lr = 1, last_lr = 1;

    task automatic step();
        int bitn, b;
        logic e_lr, e_sdo;
        logic [DW-1:0] w;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (n < 2 * SD) begin
            e_lr = 1'b1; e_sdo = 1'b0;
        end else begin
            bitn  = ((n / (2 * SD)) - 1) % (2 * FW);
            e_lr  = (bitn >= FW);
            b     = bitn % FW;
            w     = e_lr ? m_cr : m_cl;
            e_sdo = (b >= 1 && b <= DW) ? w[DW-b] : 1'b0;
        end
        check("sclk",     32'(sclk),      32'((n / SD) % 2));
        check("lrclk",    32'(lrclk),     32'(e_lr));
        check("sdo",      32'(sdo),       32'(e_sdo));
        check("ready",    32'(bus.ready), 32'(!m_full));
        check("underrun", 32'(underrun),  32'(m_und));

        if (!rst) begin
            rx_pos = 0; prev_sclk = 0; prev_lr = 1; last_lr = 1; last_rise = -1;
        end else begin
            if (lrclk && !prev_lr) begin
                if (last_rise >= 0)
                    check("lr_period", 32'(cyc - last_rise), 32'(FRAME));
                last_rise = cyc;
            end
            if (sclk && !prev_sclk) begin
                if (lrclk != last_lr) rx_pos = 0;
                else rx_pos++;
                last_lr = lrclk;
                if (rx_pos >= 1 && rx_pos <= DW) rx_word = {rx_word[DW-2:0], sdo};
                if (rx_pos == DW) begin
                    if (!lrclk) rx_left = rx_word;
                    else begin
                        rx_lq.push_back(rx_left);
                        rx_rq.push_back(rx_word);
                    end
                end
            end
            prev_sclk = sclk;
            prev_lr   = lrclk;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic set_rand();
        bus.ldata = DW'($urandom) | DW'(1);
        bus.rdata = DW'($urandom) | DW'(1);
    endtask

    // keep valid high with fresh data after every accept; records what was pushed
    task automatic stream(input int cycles);
        push_lq.delete(); push_rq.delete();
        bus.valid = 1'b1;
        set_rand();
        for (int i = 0; i < cycles; i++) begin
            step();
            if (m_acc) begin
                push_lq.push_back(m_bl);
                push_rq.push_back(m_br);
                set_rand();
            end
        end
        bus.valid = 1'b0;
    endtask

    task automatic check_rx(input string tag, input int start);
        check({tag, "_count"}, 32'(rx_lq.size() >= start + push_lq.size()), 32'd1);
        for (int i = 0; i < push_lq.size(); i++) begin
            if (start + i < rx_lq.size()) begin
                check({tag, "_left"},  32'(rx_lq[start+i]), 32'(push_lq[i]));
                check({tag, "_right"}, 32'(rx_rq[start+i]), 32'(push_rq[i]));
            end
        end
    endtask

    initial begin
        int und_cnt, guard, start;
        logic [DW-1:0] x_l, x_r;
        bus.valid = 1'b0;
        bus.ldata = '0;
        bus.rdata = '0;

        rst = 1'b0;
        run(3);
        rst = 1'b1;

        // single known sample carried by frame 0
        rx_lq.delete(); rx_rq.delete();
        bus.valid = 1'b1;
        bus.ldata = 24'hA5C3F0;
        bus.rdata = 24'h5A3C0F;
        step();
        bus.valid = 1'b0;
        run(2 * FRAME);
        check("f0_count", 32'(rx_lq.size() >= 2), 32'd1);
        if (rx_lq.size() >= 2) begin
            check("f0_left",  32'(rx_lq[0]), 32'h00A5C3F0);
            check("f0_right", 32'(rx_rq[0]), 32'h005A3C0F);
            check("f1_zero",  32'(rx_lq[1] | rx_rq[1]), 32'd0);
        end

        // back-to-back samples, one per frame
        start = rx_lq.size();
        stream(4 * FRAME);
        run(2 * FRAME);
        check_rx("stream", start);

        // idle: one underrun per frame
        und_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (underrun) und_cnt++;
        end
        check("idle_underruns", 32'(und_cnt), 32'd3);

        // valid coincides with a frame load while empty
        guard = 0;
        while (!is_load(n + 1) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("align_timeout", 32'(guard < 2 * FRAME), 32'd1);
        start = rx_lq.size();
        x_l = DW'($urandom) | DW'(1);
        x_r = DW'($urandom) | DW'(1);
        bus.valid = 1'b1;
        bus.ldata = x_l;
        bus.rdata = x_r;
        step();
        bus.valid = 1'b0;
        check("coinc_underrun", 32'(underrun),  32'd1);
        check("coinc_ready",    32'(bus.ready), 32'd0);
        run(2 * FRAME + 16);
        check("coinc_count", 32'(rx_lq.size() >= start + 2), 32'd1);
        if (rx_lq.size() >= start + 2) begin
            check("coinc_zero",  32'(rx_lq[start] | rx_rq[start]), 32'd0);
            check("coinc_left",  32'(rx_lq[start+1]), 32'(x_l));
            check("coinc_right", 32'(rx_rq[start+1]), 32'(x_r));
        end

        // reset in the right slot with a sample buffered
        bus.valid = 1'b1;
        set_rand();
        guard = 0;
        do begin
            step();
            if (m_acc) bus.valid = 1'b0;
            guard++;
        end while (!(m_full && n >= 2 * SD && (((n / (2 * SD)) - 1) % (2 * FW)) >= FW + 4)
                   && guard < 2 * FRAME);
        bus.valid = 1'b0;
        check("midrst_timeout", 32'(guard < 2 * FRAME), 32'd1);
        rst = 1'b0;
        step();
        check("rst_sclk",  32'(sclk),      32'd0);
        check("rst_lrclk", 32'(lrclk),     32'd1);
        check("rst_sdo",   32'(sdo),       32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        rst = 1'b1;
        rx_lq.delete(); rx_rq.delete();
        stream(3 * FRAME);
        run(2 * FRAME);
        check_rx("after_rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
